// File: rtl/seg7_scan_display.sv
// seg7_scan_display: N-digit hex value register driving a time-multiplexed
// 7-segment display. A two-state scan FSM alternates a guard interval (all
// anodes off) with a show interval for one digit. It can optionally blank
// leading zeros. All display outputs are registered.
module seg7_scan_display #(
    parameter int NUM_DIGITS    = 4,
    parameter int REFRESH_DIV   = 10000,
    parameter int GUARD_CYCLES  = 16,
    parameter int ACTIVE_LOW    = 1,
    parameter int BLANK_LEADING = 1,
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    dp_ce,
    input  logic [4*NUM_DIGITS-1:0] din,
    output logic [4*NUM_DIGITS-1:0] dp_o,
    output logic [6:0]              dp_out,
    output logic [NUM_DIGITS-1:0]   dp_an,
    output logic [IDX_W-1:0]        digit_idx
);

    localparam int CNT_MAX = (REFRESH_DIV > GUARD_CYCLES) ? REFRESH_DIV : GUARD_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0]      SHOW_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0]      GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [6:0]            SEG_OFF    = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [NUM_DIGITS-1:0] AN_OFF     = (ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}}
                                                                     : {NUM_DIGITS{1'b0}};

    typedef enum logic {ST_BLANK, ST_SHOW} state_t;

    state_t                  state;
    logic [CNT_W-1:0]        presc;
    logic [NUM_DIGITS-1:0]   blank_vec;
    logic                    zero_above;
    logic [3:0]              cur_nib;
    logic                    cur_blank;
    logic [NUM_DIGITS-1:0]   cur_onehot;
    logic [6:0]              seg_al;
    logic [6:0]              next_seg;
    logic [NUM_DIGITS-1:0]   next_an;

    // Hex nibble to active-low segment pattern {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        case (nib)
            4'h0:    return 7'b1000000;
            4'h1:    return 7'b1111001;
            4'h2:    return 7'b0100100;
            4'h3:    return 7'b0110000;
            4'h4:    return 7'b0011001;
            4'h5:    return 7'b0010010;
            4'h6:    return 7'b0000010;
            4'h7:    return 7'b1111000;
            4'h8:    return 7'b0000000;
            4'h9:    return 7'b0010000;
            4'hA:    return 7'b0001000;
            4'hB:    return 7'b0000011;
            4'hC:    return 7'b1000110;
            4'hD:    return 7'b0100001;
            4'hE:    return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    // Value register: loads din when enabled, holds otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_o <= '0;
        end else if (dp_ce) begin
            dp_o <= din;
        end
    end

    // Leading-zero mask: digit k>0 is blank when it and every higher digit are zero
    always_comb begin
        blank_vec  = '0;
        zero_above = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            zero_above   = zero_above & (dp_o[4*k +: 4] == 4'h0);
            blank_vec[k] = (BLANK_LEADING != 0) && zero_above;
        end
    end

    // Segment and anode pattern for the digit about to be shown
    always_comb begin
        cur_nib    = 4'h0;
        cur_blank  = 1'b0;
        cur_onehot = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (digit_idx == IDX_W'(k)) begin
                cur_nib       = dp_o[4*k +: 4];
                cur_blank     = blank_vec[k];
                cur_onehot[k] = 1'b1;
            end
        end
        seg_al   = cur_blank ? 7'h7F : hex_to_seg(cur_nib);
        next_seg = (ACTIVE_LOW != 0) ? seg_al : ~seg_al;
        next_an  = (ACTIVE_LOW != 0) ? ~cur_onehot : cur_onehot;
    end

    // Scan FSM: guard interval, then show one digit, then advance the index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_BLANK;
            presc     <= '0;
            digit_idx <= '0;
            dp_out    <= SEG_OFF;
            dp_an     <= AN_OFF;
        end else begin
            case (state)
                ST_BLANK: begin
                    if (presc == GUARD_LAST) begin
                        state  <= ST_SHOW;
                        presc  <= '0;
                        dp_out <= next_seg;
                        dp_an  <= next_an;
                    end else begin
                        presc <= presc + 1'b1;
                    end
                end
                ST_SHOW: begin
                    if (presc == SHOW_LAST) begin
                        state     <= ST_BLANK;
                        presc     <= '0;
                        dp_out    <= SEG_OFF;
                        dp_an     <= AN_OFF;
                        digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
                    end else begin
                        presc <= presc + 1'b1;
                    end
                end
                default: begin
                    state  <= ST_BLANK;
                    presc  <= '0;
                    dp_out <= SEG_OFF;
                    dp_an  <= AN_OFF;
                end
            endcase
        end
    end

endmodule
